deser_rx_ctrl: RTL and testbench
================================

DESER_RX_CTRL -- requirements
Module: deser_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width of the attached deserializer.
REQ-002 SHALL have parameter FRAME_WORDS, default 4: words per frame, range 1..255.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 4: clocks per serial bit, even, >=4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port clear_i  input  1  synchronous clear of overflow_o and err_count_o.
REQ-009 SHALL have port deser_serial_o  output  1  synchronized rx bit to the deserializer.
REQ-010 SHALL have port deser_enable_o  output  1  one-clock shift strobe per bit.
REQ-011 SHALL have port deser_start_o  output  1  word-start marker, coincident with the first enable of each word.
REQ-012 SHALL have port deser_valid_i  input  1  deserializer word valid.
REQ-013 SHALL have port deser_data_i  input  DATA_WIDTH  deserializer word.
REQ-014 SHALL have port deser_errors_i  input  2  corrected/detected error count for the word.
REQ-015 SHALL have port data_o  output  DATA_WIDTH  FIFO head word.
REQ-016 SHALL have port valid_o  output  1  FIFO non-empty.
REQ-017 SHALL have port ready_i  input  1  consumer accept.
REQ-018 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-019 SHALL have port frame_done_o  output  1  one-clock pulse at frame end.
REQ-020 SHALL have port overflow_o  output  1  sticky: a word was dropped.
REQ-021 SHALL have port err_count_o  output  8  saturating sum of deser_errors_i.

Function
REQ-022 SHALL pass rx_i through a 2-flop synchronizer; deser_serial_o is the second flop output.
REQ-023 SHALL implement FSM IDLE, START, DATA, WAIT, with IDLE -> START on the synchronized falling edge (1 then 0).
REQ-024 SHALL, in START, resample at CLKS_PER_BIT/2 clocks after the edge: go to DATA if low, otherwise return to IDLE (glitch reject).
REQ-025 SHALL, in DATA, pulse deser_enable_o every CLKS_PER_BIT clocks, first pulse CLKS_PER_BIT clocks after the START sample, sampling mid-bit.
REQ-026 SHALL assert deser_start_o on enable pulses 0, DATA_WIDTH, 2*DATA_WIDTH, ... (first bit of every word).
REQ-027 SHALL leave DATA for WAIT after enable pulse number FRAME_WORDS*DATA_WIDTH (the last one).
REQ-028 SHALL, in WAIT, return to IDLE on the first cycle in which FRAME_WORDS words have been received, or after a 4-clock timeout; frame_done_o pulses on that transition in either case.
REQ-029 SHALL accept deser_valid_i in any state: count it and push deser_data_i into the FIFO.
REQ-030 SHALL drop the word and set overflow_o if the FIFO is full and no pop occurs in the same cycle.
REQ-031 SHALL treat simultaneous push and pop on a full FIFO as legal with no overflow.
REQ-032 SHALL pop the FIFO on valid_o && ready_i; data_o is held stable while valid_o && !ready_i; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-033 SHALL add deser_errors_i to err_count_o on each deser_valid_i, saturating at 255.
REQ-034 SHALL make clear_i take priority over a same-cycle overflow set or error add, leaving overflow_o=0 and err_count_o=0 afterwards.
REQ-035 SHALL ignore rx_i edges outside IDLE; line activity mid-frame does not restart the frame.

Reset
REQ-036 SHALL, while rst_n_i=0, asynchronously force: FSM IDLE, synchronizer flops 1, FIFO empty, valid_o=0, data_o=0, deser_enable_o=0, deser_start_o=0, busy_o=0, frame_done_o=0, overflow_o=0, err_count_o=0.
REQ-037 SHALL abandon any in-progress frame on reset assertion and SHALL NOT emit frame_done_o for it.

Verification
REQ-038 SHALL be verified with: DATA_WIDTH=8, FRAME_WORDS=2, CLKS_PER_BIT=4, bits 0xA5, 0x3C, ready_i=1 -> 16 enables spaced 4 clocks, deser_start_o on enables 0 and 8, deser_serial_o sequence matching both words, one frame_done_o pulse.
REQ-039 SHALL be verified with: a 1-clock low glitch on rx_i -> START returns to IDLE with no enable pulse.
REQ-040 SHALL be verified with: ready_i=0, FIFO_DEPTH=4, 5 deser_valid_i pulses -> 4 words held, overflow_o=1, then ready_i=1 drains the words in push order.
REQ-041 SHALL be verified with: deser_errors_i=2 on 130 words -> err_count_o=255; clear_i -> 0.
REQ-042 SHALL be verified with: deser_valid_i withheld after the last bit -> WAIT times out after 4 clocks, frame_done_o pulses, FSM reaches IDLE.
REQ-043 SHALL be verified with: rst_n_i low mid-DATA -> all outputs reach reset values immediately without a clock edge, and no frame_done_o.

Source files
------------

// File: rtl/deser_rx_ctrl.sv
// Receive controller for an attached serial deserializer: line synchronizer, bit-timing FSM,
// output word FIFO, and overflow / error-count status.
module deser_rx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FRAME_WORDS  = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_i,
  input  logic                  clear_i,
  output logic                  deser_serial_o,
  output logic                  deser_enable_o,
  output logic                  deser_start_o,
  input  logic                  deser_valid_i,
  input  logic [DATA_WIDTH-1:0] deser_data_i,
  input  logic [1:0]            deser_errors_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  overflow_o,
  output logic [7:0]            err_count_o
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   PULSE_SET = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(3);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [7:0]      FW8       = 8'(FRAME_WORDS);
  localparam logic [AW-1:0]   PTR_LAST  = AW'(FIFO_DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, WAIT} state_t;

  state_t          state;
  logic            sync1, sync2, sync_prev;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;
  logic [7:0]      word_cnt;
  logic [7:0]      rx_words;
  logic [7:0]      words_seen;
  logic            fall;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            full, pop, accept, drop;
  logic [8:0]      err_sum;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rx_i;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign deser_serial_o = sync2;
  assign fall           = sync_prev & ~sync2;
  assign busy_o         = (state != IDLE);

  // Words received this frame including the current cycle's strobe, so WAIT can exit immediately.
  always_comb begin
    words_seen = rx_words;
    if (deser_valid_i && (rx_words != 8'hFF)) words_seen = rx_words + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      word_cnt       <= '0;
      rx_words       <= '0;
      deser_enable_o <= 1'b0;
      deser_start_o  <= 1'b0;
      frame_done_o   <= 1'b0;
    end else begin
      deser_enable_o <= 1'b0;
      deser_start_o  <= 1'b0;
      frame_done_o   <= 1'b0;
      rx_words       <= words_seen;
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            cnt      <= '0;
            rx_words <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sync2) begin
              state    <= DATA;
              bit_idx  <= '0;
              word_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          // Strobe is registered one clock ahead so it is high on the mid-bit cycle (cnt == BIT_LAST).
          if (cnt == PULSE_SET) begin
            deser_enable_o <= 1'b1;
            deser_start_o  <= (bit_idx == '0);
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              word_cnt <= word_cnt + 8'd1;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (word_cnt == FW8) state <= WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if ((words_seen >= FW8) || (cnt == WAIT_LAST)) begin
            state        <= IDLE;
            cnt          <= '0;
            frame_done_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == FULL_CNT);
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i;
  assign accept  = deser_valid_i & (~full | pop);
  assign drop    = deser_valid_i & full & ~pop;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= deser_data_i;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  assign err_sum = {1'b0, err_count_o} + {7'b0, deser_errors_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o  <= 1'b0;
      err_count_o <= '0;
    end else if (clear_i) begin
      overflow_o  <= 1'b0;
      err_count_o <= '0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      if (deser_valid_i) err_count_o <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_deser_rx_ctrl.sv
// Directed bench for deser_rx_ctrl: serial frames, glitch reject, WAIT timeout, FIFO overflow,
// error saturation and asynchronous reset, with queued expectations checked by a negedge monitor.
module tb_deser_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       clear = 1'b0;
  logic       deser_valid = 1'b0;
  logic [7:0] deser_data = '0;
  logic [1:0] deser_errors = '0;
  logic       ready = 1'b1;
  logic       deser_serial, deser_enable, deser_start;
  logic [7:0] data;
  logic       valid, busy, frame_done, overflow;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_en_cyc = 0;
  int en_total = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  bit first_en = 1'b1;
  int en0, fd0;
  bit busy_seen;

  logic [1:0] bit_q[$];
  logic [7:0] data_q[$];
  logic [1:0] mon_bit;
  logic [7:0] mon_word;

  deser_rx_ctrl #(
    .DATA_WIDTH(8),
    .FRAME_WORDS(2),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_i(rx),
    .clear_i(clear),
    .deser_serial_o(deser_serial),
    .deser_enable_o(deser_enable),
    .deser_start_o(deser_start),
    .deser_valid_i(deser_valid),
    .deser_data_i(deser_data),
    .deser_errors_i(deser_errors),
    .data_o(data),
    .valid_o(valid),
    .ready_i(ready),
    .busy_o(busy),
    .frame_done_o(frame_done),
    .overflow_o(overflow),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every enable pops an expected {bit,start}; every FIFO pop pops an expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (deser_enable) begin
        en_total++;
        if (!first_en) chk("en_spacing", 32'(cyc - last_en_cyc), 32'd4);
        first_en = 1'b0;
        last_en_cyc = cyc;
        chk("en_expected", 32'(bit_q.size() != 0), 32'd1);
        if (bit_q.size() != 0) begin
          mon_bit = bit_q.pop_front();
          chk("serial_bit", 32'(deser_serial), 32'(mon_bit[1]));
          chk("start_flag", 32'(deser_start), 32'(mon_bit[0]));
        end
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (valid && ready) begin
        chk("pop_expected", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) begin
          mon_word = data_q.pop_front();
          chk("data_o", 32'(data), 32'(mon_word));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic send_frame(input logic [15:0] bits, input int n, input logic mid_en,
                            input logic [7:0] mid_data);
    first_en = 1'b1;
    for (int k = 0; k < n; k++) bit_q.push_back({bits[k], 1'(k % 8 == 0)});
    for (int b = 0; b <= n; b++) begin
      rx = (b == 0) ? 1'b0 : bits[b-1];
      for (int c = 0; c < 4; c++) begin
        if (mid_en && b == 9 && c == 0) begin
          deser_valid = 1'b1;
          deser_data  = mid_data;
          data_q.push_back(mid_data);
        end else begin
          deser_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    rx = 1'b1;
    deser_valid = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic [1:0] e, input logic expect_pop);
    deser_valid  = 1'b1;
    deser_data   = d;
    deser_errors = e;
    if (expect_pop) data_q.push_back(d);
    @(posedge clk); #1;
    deser_valid  = 1'b0;
    deser_errors = '0;
  endtask

  initial begin
    // Reset values while reset is held.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_serial", 32'(deser_serial), 32'd1);
    chk("rst_enable", 32'(deser_enable), 32'd0);
    chk("rst_start", 32'(deser_start), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word frame 0xA5, 0x3C; words delivered before WAIT so it exits on the word count.
    en0 = en_total; fd0 = fd_count;
    send_frame(16'h3CA5, 16, 1'b1, 8'hA5);
    deser_valid = 1'b1; deser_data = 8'h3C; data_q.push_back(8'h3C);
    @(posedge clk); #1;
    deser_valid = 1'b0;
    for (int i = 0; i < 20 && fd_count == fd0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("frame_done_count", 32'(fd_count - fd0), 32'd1);
    chk("frame_enables", 32'(en_total - en0), 32'd16);
    chk("frame_done_delay", 32'(fd_cyc - last_en_cyc), 32'd2);
    chk("frame_busy_end", 32'(busy), 32'd0);
    chk("frame_bits_left", 32'(bit_q.size()), 32'd0);
    chk("frame_words_left", 32'(data_q.size()), 32'd0);

    // One-clock low glitch: START entered, then rejected.
    en0 = en_total; fd0 = fd_count;
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy_end", 32'(busy), 32'd0);
    chk("glitch_enables", 32'(en_total - en0), 32'd0);
    chk("glitch_frame_done", 32'(fd_count - fd0), 32'd0);

    // Frame with no words delivered: WAIT times out after 4 clocks.
    @(posedge clk); #1;
    en0 = en_total; fd0 = fd_count;
    send_frame(16'h5AC3, 16, 1'b0, 8'h00);
    for (int i = 0; i < 20 && fd_count == fd0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("timeout_done_count", 32'(fd_count - fd0), 32'd1);
    chk("timeout_delay", 32'(fd_cyc - last_en_cyc), 32'd5);
    chk("timeout_enables", 32'(en_total - en0), 32'd16);
    chk("timeout_busy_end", 32'(busy), 32'd0);

    // FIFO fill with consumer stalled; fifth word is dropped.
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_word(8'(17 * (i + 1)), 2'd0, 1'(i < 4));
      if (i == 3) chk("fifo_no_overflow_at_full", 32'(overflow), 32'd0);
    end
    chk("fifo_overflow", 32'(overflow), 32'd1);
    chk("fifo_valid_full", 32'(valid), 32'd1);
    chk("fifo_head", 32'(data), 32'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("fifo_head_held", 32'(data), 32'h11);
    ready = 1'b1;
    for (int i = 0; i < 20 && (data_q.size() != 0 || valid); i++) @(negedge clk);
    chk("fifo_drained", 32'(data_q.size()), 32'd0);
    chk("fifo_empty_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_overflow", 32'(overflow), 32'd0);

    // Push and pop together on a full FIFO is not an overflow.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h21 + i), 2'd0, 1'b1);
    ready = 1'b1;
    push_word(8'h66, 2'd0, 1'b1);
    chk("full_pushpop_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 20 && (data_q.size() != 0 || valid); i++) @(negedge clk);
    chk("full_pushpop_drained", 32'(data_q.size()), 32'd0);

    // Error count saturation, then clear winning over a same-cycle add.
    @(posedge clk); #1;
    for (int i = 0; i < 130; i++) begin
      push_word(8'(i), 2'd2, 1'b1);
      if (i == 126) chk("err_254", 32'(err_count), 32'd254);
      if (i == 127) chk("err_sat_first", 32'(err_count), 32'd255);
    end
    chk("err_sat_130", 32'(err_count), 32'd255);
    clear = 1'b1;
    push_word(8'hEE, 2'd3, 1'b1);
    clear = 1'b0;
    chk("err_clear_priority", 32'(err_count), 32'd0);
    for (int i = 0; i < 20 && (data_q.size() != 0 || valid); i++) @(negedge clk);
    chk("err_words_drained", 32'(data_q.size()), 32'd0);

    // Load state, then assert reset mid-DATA while an enable strobe is high.
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(8'h80 + i), 2'd1, 1'b0);
    chk("pre_reset_err", 32'(err_count), 32'd5);
    chk("pre_reset_overflow", 32'(overflow), 32'd1);
    en0 = en_total; fd0 = fd_count;
    send_frame(16'h001D, 6, 1'b0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 8 && !deser_enable; i++) @(negedge clk);
    chk("pre_reset_enable", 32'(deser_enable), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_serial", 32'(deser_serial), 32'd1);
    chk("arst_enable", 32'(deser_enable), 32'd0);
    chk("arst_start", 32'(deser_start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("arst_no_frame_done", 32'(fd_count - fd0), 32'd0);
    chk("arst_enables", 32'(en_total - en0), 32'd6);
    chk("arst_bits_left", 32'(bit_q.size()), 32'd0);
    chk("arst_busy_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
